// File: rtl/branch_cmp_pkg.sv
// Shared definitions for the branch compare unit: RISC-V branch funct3 encodings
// and the result record produced by the compare core.
package branch_cmp_pkg;

  typedef logic [2:0] cmp_op_t;

  localparam cmp_op_t CMP_EQ  = 3'b000;
  localparam cmp_op_t CMP_NE  = 3'b001;
  localparam cmp_op_t CMP_LT  = 3'b100;
  localparam cmp_op_t CMP_GE  = 3'b101;
  localparam cmp_op_t CMP_LTU = 3'b110;
  localparam cmp_op_t CMP_GEU = 3'b111;

  typedef struct packed {
    logic taken;
    logic illegal;
  } cmp_res_t;

endpackage

// File: rtl/branch_cmp_core.sv
// Pure combinational branch compare. Unsigned compares exist only when
// BRANCH_CMP_UNSIGNED_EN is defined; otherwise 110/111 report illegal.
module branch_cmp_core
  import branch_cmp_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rs1,
  input  logic [DATA_W-1:0] rs2,
  input  cmp_op_t           op,
  output cmp_res_t          res
);

  logic eq;
  logic lt_s;

  assign eq   = (rs1 == rs2);
  assign lt_s = ($signed(rs1) < $signed(rs2));

`ifdef BRANCH_CMP_UNSIGNED_EN
  logic lt_u;
  assign lt_u = (rs1 < rs2);
`endif

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    res = '0;
    case (op)
      CMP_EQ:  res.taken = eq;
      CMP_NE:  res.taken = !eq;
      CMP_LT:  res.taken = lt_s;
      CMP_GE:  res.taken = !lt_s;
`ifdef BRANCH_CMP_UNSIGNED_EN
      CMP_LTU: res.taken = lt_u;
      CMP_GEU: res.taken = !lt_u;
`endif
      default: res.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_compare_unit.sv
// Valid/ready pipelined branch comparator, 1 or 2 stages, with flush and a
// returned sideband tag. Optional unsigned ops: BRANCH_CMP_UNSIGNED_EN.
module branch_compare_unit
  import branch_cmp_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4,
  parameter int LATENCY = 1
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] COMP1,
  input  logic [DATA_W-1:0] COMP2,
  input  logic [2:0]        CMP_OP,
  input  logic [TAG_W-1:0]  IN_TAG,
  input  logic              FLUSH,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              COMP_OUT,
  output logic              CMP_ILLEGAL,
  output logic [TAG_W-1:0]  OUT_TAG
);

  if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
    $error("branch_compare_unit: LATENCY must be 1 or 2");
  end

  logic              in_ready;
  logic              accept;
  logic              out_adv;
  logic              fin_valid;
  logic [DATA_W-1:0] fin_a;
  logic [DATA_W-1:0] fin_b;
  cmp_op_t           fin_op;
  logic [TAG_W-1:0]  fin_tag;
  cmp_res_t          fin_res;

  logic              out_valid_q, out_valid_d;
  cmp_res_t          res_q, res_d;
  logic [TAG_W-1:0]  tag_q, tag_d;

  // The output stage may load when it is empty or its result is being consumed.
  assign out_adv = !out_valid_q || OUT_READY;

  if (LATENCY == 2) begin : g_two_stage
    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_a_q, s1_a_d;
    logic [DATA_W-1:0] s1_b_q, s1_b_d;
    cmp_op_t           s1_op_q, s1_op_d;
    logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
    logic              s1_open;

    always_comb begin
      s1_open    = !s1_valid_q || out_adv;
      in_ready   = RSTN && !FLUSH && s1_open;
      accept     = IN_VALID && in_ready;
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_op_d    = s1_op_q;
      s1_tag_d   = s1_tag_q;
      if (FLUSH) begin
        s1_valid_d = 1'b0;
      end else if (s1_open) begin
        s1_valid_d = accept;
        if (accept) begin
          s1_a_d   = COMP1;
          s1_b_d   = COMP2;
          s1_op_d  = CMP_OP;
          s1_tag_d = IN_TAG;
        end
      end
    end

    always_ff @(posedge CLK) begin
      if (!RSTN) begin
        s1_valid_q <= 1'b0;
        s1_a_q     <= '0;
        s1_b_q     <= '0;
        s1_op_q    <= '0;
        s1_tag_q   <= '0;
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_a_q     <= s1_a_d;
        s1_b_q     <= s1_b_d;
        s1_op_q    <= s1_op_d;
        s1_tag_q   <= s1_tag_d;
      end
    end

    always_comb begin
      fin_valid = s1_valid_q;
      fin_a     = s1_a_q;
      fin_b     = s1_b_q;
      fin_op    = s1_op_q;
      fin_tag   = s1_tag_q;
    end
  end else begin : g_one_stage
    always_comb begin
      in_ready  = RSTN && !FLUSH && out_adv;
      accept    = IN_VALID && in_ready;
      fin_valid = accept;
      fin_a     = COMP1;
      fin_b     = COMP2;
      fin_op    = CMP_OP;
      fin_tag   = IN_TAG;
    end
  end

  branch_cmp_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .rs1 (fin_a),
    .rs2 (fin_b),
    .op  (fin_op),
    .res (fin_res)
  );

  // Result data only changes when a real result enters, so outputs stay quiet while idle.
  always_comb begin
    out_valid_d = out_valid_q;
    res_d       = res_q;
    tag_d       = tag_q;
    if (FLUSH) begin
      out_valid_d = 1'b0;
    end else if (out_adv) begin
      out_valid_d = fin_valid;
      if (fin_valid) begin
        res_d = fin_res;
        tag_d = fin_tag;
      end
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: data registers are reset as well as valid bits, so every output reads 0 after reset.
    if (!RSTN) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      tag_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops update together from pre-edge values.
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      tag_q       <= tag_d;
    end
  end

  assign IN_READY    = in_ready;
  assign OUT_VALID   = out_valid_q;
  assign COMP_OUT    = res_q.taken;
  assign CMP_ILLEGAL = res_q.illegal;
  assign OUT_TAG     = tag_q;

endmodule

// File: tb/tb_branch_compare_unit.sv
// Self-checking bench: a 1-stage and a 2-stage instance run directed scenarios and
// randomized traffic against an arithmetic reference model with per-instance scoreboards.
module tb_branch_compare_unit;

  localparam int DW = 32;
  localparam int TW = 4;

  typedef struct packed {
    logic          taken;
    logic          illegal;
    logic [TW-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic [1:0]    in_valid, in_ready, flush, out_valid, out_ready, comp_out, cmp_ill;
  logic [DW-1:0] comp1 [2];
  logic [DW-1:0] comp2 [2];
  logic [2:0]    cmp_op [2];
  logic [TW-1:0] in_tag [2];
  logic [TW-1:0] out_tag [2];

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  branch_compare_unit #(.DATA_W(DW), .TAG_W(TW), .LATENCY(1)) dut1 (
    .CLK(clk), .RSTN(rstn), .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]),
    .COMP1(comp1[0]), .COMP2(comp2[0]), .CMP_OP(cmp_op[0]), .IN_TAG(in_tag[0]),
    .FLUSH(flush[0]), .OUT_VALID(out_valid[0]), .OUT_READY(out_ready[0]),
    .COMP_OUT(comp_out[0]), .CMP_ILLEGAL(cmp_ill[0]), .OUT_TAG(out_tag[0])
  );

  branch_compare_unit #(.DATA_W(DW), .TAG_W(TW), .LATENCY(2)) dut2 (
    .CLK(clk), .RSTN(rstn), .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]),
    .COMP1(comp1[1]), .COMP2(comp2[1]), .CMP_OP(cmp_op[1]), .IN_TAG(in_tag[1]),
    .FLUSH(flush[1]), .OUT_VALID(out_valid[1]), .OUT_READY(out_ready[1]),
    .COMP_OUT(comp_out[1]), .CMP_ILLEGAL(cmp_ill[1]), .OUT_TAG(out_tag[1])
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: operands as plain integers, decision by the branch rules. Returns {taken, illegal}.
  function automatic logic [1:0] ref_cmp(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [2:0] op);
    longint ua, ub, sa, sb;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= (longint'(1) <<< (DW - 1))) ? ua - (longint'(1) <<< DW) : ua;
    sb = (ub >= (longint'(1) <<< (DW - 1))) ? ub - (longint'(1) <<< DW) : ub;
    case (op)
      3'd0: return {ua == ub, 1'b0};
      3'd1: return {ua != ub, 1'b0};
      3'd4: return {sa < sb, 1'b0};
      3'd5: return {sa >= sb, 1'b0};
`ifdef BRANCH_CMP_UNSIGNED_EN
      3'd6: return {ua < ub, 1'b0};
      3'd7: return {ua >= ub, 1'b0};
`endif
      default: return 2'b01;
    endcase
  endfunction

  function automatic exp_t mk_exp(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  input logic [2:0] op, input logic [TW-1:0] tag);
    logic [1:0] r;
    r = ref_cmp(a, b, op);
    return '{taken: r[1], illegal: r[0], tag: tag};
  endfunction

  // Scoreboard per instance: the queue holds every accepted, not yet consumed request.
  for (genvar k = 0; k < 2; k++) begin : g_sb
    exp_t q[$];
    int   acc = 0;
    always @(negedge clk) begin
      int   sz;
      exp_t f;
      if (mon_en) begin
        sz = q.size();
        check($sformatf("in_ready%0d", k), in_ready[k],
              rstn && !flush[k] && ((sz < k + 1) || out_ready[k]));
        if (sz == 0) begin
          check($sformatf("idle_valid%0d", k), out_valid[k], 1'b0);
        end else if (out_valid[k]) begin
          f = q[0];
          check($sformatf("taken%0d", k), comp_out[k], f.taken);
          check($sformatf("illegal%0d", k), cmp_ill[k], f.illegal);
          check($sformatf("tag%0d", k), out_tag[k], f.tag);
        end
        if (!rstn || flush[k]) begin
          q.delete();
        end else begin
          if (out_valid[k] && out_ready[k] && sz > 0) void'(q.pop_front());
          if (in_valid[k] && in_ready[k]) begin
            q.push_back(mk_exp(comp1[k], comp2[k], cmp_op[k], in_tag[k]));
            acc++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int k);
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    flush[k]     = 1'b0;
    comp1[k]     = '0;
    comp2[k]     = '0;
    cmp_op[k]    = '0;
    in_tag[k]    = '0;
  endtask

  task automatic drive(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [2:0] op, input logic [TW-1:0] tag);
    in_valid[k] = 1'b1;
    comp1[k]    = a;
    comp2[k]    = b;
    cmp_op[k]   = op;
    in_tag[k]   = tag;
  endtask

  function automatic logic [DW-1:0] rnd_operand();
    logic [DW-1:0] corners [5];
    corners[0] = '0;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'h7FFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'hFFFF_FFFF;
    if ($urandom_range(9) < 3) return corners[$urandom_range(4)];
    return $urandom();
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]    r;
    int            base;
    logic [DW-1:0] a;
    rstn = 1'b0;
    idle(0);
    idle(1);

    // Reset state
    tick();
    mon_en = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_valid%0d", k), out_valid[k], 1'b0);
      check($sformatf("rst_comp%0d", k), comp_out[k], 1'b0);
      check($sformatf("rst_ill%0d", k), cmp_ill[k], 1'b0);
      check($sformatf("rst_tag%0d", k), out_tag[k], '0);
      check($sformatf("rst_rdy%0d", k), in_ready[k], 1'b0);
    end
    rstn = 1'b1;
    #1;
    check("rel_rdy0", in_ready[0], 1'b1);
    check("rel_rdy1", in_ready[1], 1'b1);
    tick();

    // Signed vs unsigned on -1 / 1, LATENCY=1
    drive(0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 4'h1);
    tick();
    check("lt_valid", out_valid[0], 1'b1);
    check("lt_taken", comp_out[0], 1'b1);
    drive(0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 4'h2);
    tick();
    r = ref_cmp(32'hFFFF_FFFF, 32'h0000_0001, 3'b110);
    check("ltu_valid", out_valid[0], 1'b1);
    check("ltu_taken", comp_out[0], 1'b0);
    check("ltu_ill", cmp_ill[0], r[0]);

    // Illegal op 010 carries its tag
    drive(0, $urandom(), $urandom(), 3'b010, 4'h5);
    tick();
    check("ill_taken", comp_out[0], 1'b0);
    check("ill_flag", cmp_ill[0], 1'b1);
    check("ill_tag", out_tag[0], 4'h5);
    idle(0);
    tick();
    check("l1_drained", out_valid[0], 1'b0);

    // Four back-to-back requests, LATENCY=2
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1, 32'd7, 32'd7, 3'b000, 4'(i + 1));
      else in_valid[1] = 1'b0;
      tick();
      if (i == 0 || i == 5) begin
        check($sformatf("b2b_valid%0d", i), out_valid[1], 1'b0);
      end else begin
        check($sformatf("b2b_valid%0d", i), out_valid[1], 1'b1);
        check($sformatf("b2b_tag%0d", i), out_tag[1], 4'(i));
        check($sformatf("b2b_taken%0d", i), comp_out[1], 1'b1);
      end
    end

    // Backpressure: 5 stalled cycles, exactly two accepted
    base = g_sb[1].acc;
    out_ready[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h8000_0000, 32'd3, 3'b101, 4'(8 + g_sb[1].acc - base));
      tick();
      if (i == 0) begin
        check("bp_valid0", out_valid[1], 1'b0);
      end else begin
        check($sformatf("bp_valid%0d", i), out_valid[1], 1'b1);
        check($sformatf("bp_tag%0d", i), out_tag[1], 4'h8);
        check($sformatf("bp_taken%0d", i), comp_out[1], 1'b0);
      end
    end
    check("bp_accepted", g_sb[1].acc - base, 2);
    #1;
    check("bp_rdy_low", in_ready[1], 1'b0);
    in_valid[1]  = 1'b0;
    out_ready[1] = 1'b1;
    #1;
    check("bp_rdy_release", in_ready[1], 1'b1);
    tick();
    check("bp_drain_valid", out_valid[1], 1'b1);
    check("bp_drain_tag", out_tag[1], 4'h9);
    tick();
    check("bp_empty", out_valid[1], 1'b0);

    // Flush with two requests in flight
    drive(1, 32'd1, 32'd2, 3'b001, 4'hA);
    tick();
    drive(1, 32'd1, 32'd2, 3'b001, 4'hB);
    tick();
    check("fl_pre_valid", out_valid[1], 1'b1);
    check("fl_pre_tag", out_tag[1], 4'hA);
    drive(1, 32'd1, 32'd2, 3'b001, 4'hC);
    flush[1] = 1'b1;
    #1;
    check("fl_rdy", in_ready[1], 1'b0);
    tick();
    check("fl_valid", out_valid[1], 1'b0);
    flush[1] = 1'b0;
    drive(1, 32'd5, 32'd5, 3'b000, 4'hD);
    #1;
    check("fl_new_rdy", in_ready[1], 1'b1);
    tick();
    in_valid[1] = 1'b0;
    check("fl_gap", out_valid[1], 1'b0);
    tick();
    check("fl_new_valid", out_valid[1], 1'b1);
    check("fl_new_tag", out_tag[1], 4'hD);
    tick();
    check("fl_done", out_valid[1], 1'b0);

    // op 111 on 0x80000000 vs 0 (illegal unless unsigned ops are built in)
    drive(0, 32'h8000_0000, 32'h0, 3'b111, 4'h3);
    tick();
    idle(0);
    r = ref_cmp(32'h8000_0000, 32'h0, 3'b111);
`ifndef BRANCH_CMP_UNSIGNED_EN
    check("geu_ill_lit", cmp_ill[0], 1'b1);
`endif
    check("geu_taken", comp_out[0], r[1]);
    check("geu_ill", cmp_ill[0], r[0]);

    // Reset in the middle of a stream
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'hFFFF_FFFF, 32'h0, 3'b100, 4'(i + 4));
      tick();
    end
    check("mr_busy", out_valid[1], 1'b1);
    rstn = 1'b0;
    #1;
    check("mr_rdy0", in_ready[0], 1'b0);
    check("mr_rdy1", in_ready[1], 1'b0);
    tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("mr_valid%0d", k), out_valid[k], 1'b0);
      check($sformatf("mr_comp%0d", k), comp_out[k], 1'b0);
      check($sformatf("mr_ill%0d", k), cmp_ill[k], 1'b0);
      check($sformatf("mr_tag%0d", k), out_tag[k], '0);
    end
    idle(1);
    rstn = 1'b1;
    #1;
    check("mr_rel_rdy", in_ready[1], 1'b1);
    tick();

    // Randomized traffic on both instances, scoreboard checks every cycle
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        a = rnd_operand();
        in_valid[k]  = $urandom_range(9) < 6;
        out_ready[k] = $urandom_range(9) < 7;
        flush[k]     = $urandom_range(49) == 0;
        comp1[k]     = a;
        comp2[k]     = ($urandom_range(7) == 0) ? a : rnd_operand();
        cmp_op[k]    = 3'($urandom_range(7));
        in_tag[k]    = 4'($urandom_range(15));
      end
      tick();
    end

    idle(0);
    idle(1);
    for (int i = 0; i < 6; i++) tick();
    check("drain_q0", g_sb[0].q.size(), 0);
    check("drain_q1", g_sb[1].q.size(), 0);
    check("drain_v0", out_valid[0], 1'b0);
    check("drain_v1", out_valid[1], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_compare_unit.md
BRANCH_COMPARE_UNIT -- requirements
Module: branch_compare_unit

Interface
REQ-001 Parameter DATA_W, default 32, operand width in bits (legal 8..64).
REQ-002 Parameter TAG_W, default 4, width of the sideband tag carried with each request (legal 1..16).
REQ-003 Parameter LATENCY, default 1, pipeline stages from accept to result (legal 1 or 2; any other value SHALL fail elaboration).
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RSTN  input  1  reset, synchronous, active-low.
REQ-006 IN_VALID  input  1  request present.
REQ-007 IN_READY  output  1  unit can accept a request this cycle.
REQ-008 COMP1  input  DATA_W  first operand (rs1).
REQ-009 COMP2  input  DATA_W  second operand (rs2).
REQ-010 CMP_OP  input  3  comparison select, RISC-V branch funct3 encoding.
REQ-011 IN_TAG  input  TAG_W  sideband tag, returned unchanged with the result.
REQ-012 FLUSH  input  1  discard all in-flight requests.
REQ-013 OUT_VALID  output  1  result present.
REQ-014 OUT_READY  input  1  consumer accepts the result.
REQ-015 COMP_OUT  output  1  comparison result (branch taken).
REQ-016 CMP_ILLEGAL  output  1  CMP_OP was an unsupported code.
REQ-017 OUT_TAG  output  TAG_W  tag of the presented result.

Function
REQ-018 Encodings: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU; 010 and 011 illegal -> COMP_OUT=0, CMP_ILLEGAL=1.
REQ-019 Signed compares use two's complement over DATA_W bits; unsigned compares use zero-extended magnitude; no truncation or extension of operands.
REQ-020 A request is accepted when IN_VALID=1 and IN_READY=1 in the same cycle; a result is consumed when OUT_VALID=1 and OUT_READY=1.
REQ-021 LATENCY=1: operands compared combinationally at accept and result registered; OUT_VALID asserts the cycle after accept.
REQ-022 LATENCY=2: operands, CMP_OP and tag registered in stage 1; compare and result register in stage 2; OUT_VALID asserts two cycles after accept when unstalled.
REQ-023 Each stage holds a valid bit; a stage loads when empty or when its contents move downstream in the same cycle (full throughput, one result per cycle, no bubbles under continuous OUT_READY=1).
REQ-024 IN_READY = NOT FLUSH AND (stage 1 empty OR stage 1 advancing); IN_READY depends combinationally on OUT_READY.
REQ-025 While OUT_VALID=1 and OUT_READY=0, COMP_OUT, CMP_ILLEGAL and OUT_TAG SHALL hold stable; upstream stages hold; no request is lost or duplicated.
REQ-026 Results leave in acceptance order.
REQ-027 FLUSH=1 clears every stage valid bit at the next edge; a request presented with FLUSH=1 is not accepted; a result presented during FLUSH is not considered consumed.
REQ-028 Data registers of empty stages are don't-care but SHALL not toggle outputs while OUT_VALID=0 beyond the reset value or last result.

Reset
REQ-029 RSTN=0 at a rising edge clears all valid bits and data registers; OUT_VALID=0, COMP_OUT=0, CMP_ILLEGAL=0, OUT_TAG=0.
REQ-030 IN_READY SHALL be 0 while RSTN=0 and 1 in the first cycle after release.
REQ-031 Reset asserted mid-operation discards all in-flight requests with no output handshake.

Configuration
REQ-032 Macro BRANCH_CMP_UNSIGNED_EN: when defined, 110/111 perform LTU/GEU per REQ-018.
REQ-033 When BRANCH_CMP_UNSIGNED_EN is undefined, 110 and 111 are treated as illegal (COMP_OUT=0, CMP_ILLEGAL=1) and no unsigned comparator is synthesised.

Structure
REQ-034 Shared package branch_cmp_pkg SHALL hold the CMP_OP encoding constants and the 3-bit op typedef.
REQ-035 Sub-module branch_cmp_core SHALL be the pure combinational compare (operands, op -> result, illegal), instantiated once in the final stage.

Verification
REQ-036 LATENCY=1, COMP1=0xFFFFFFFF, COMP2=0x00000001, op 100 then 110, OUT_READY=1 -> COMP_OUT=1 then 0, OUT_VALID one cycle after each accept.
REQ-037 op 010 with any operands, tag 0x5 -> COMP_OUT=0, CMP_ILLEGAL=1, OUT_TAG=0x5.
REQ-038 LATENCY=2, four back-to-back requests tags 1..4, OUT_READY=1 -> results on cycles 2..5 after first accept, tags 1,2,3,4 in order.
REQ-039 LATENCY=2, OUT_READY=0 for 5 cycles with continuous IN_VALID -> exactly two requests accepted, IN_READY=0 thereafter, outputs stable; release -> both drained in order.
REQ-040 Two requests in flight, FLUSH=1 for one cycle -> OUT_VALID=0 next cycle, no result with those tags ever appears; new request accepted the cycle after FLUSH.
REQ-041 Build without BRANCH_CMP_UNSIGNED_EN, op 111, COMP1=0x80000000, COMP2=0 -> COMP_OUT=0, CMP_ILLEGAL=1; RSTN=0 mid-stream -> OUT_VALID=0, all outputs 0 next cycle.
